// File: rtl/rv64g_pkg.sv
// Shared RV64G core definitions: register-file size, issue-path constants
// and the issue scheduler state type.
package rv64g_pkg;

  localparam int NUM_REGS     = 32;
  localparam int NUM_ISSUE_PL = 2;

  typedef enum logic {
    RUN       = 1'b0,
    JUMP_WAIT = 1'b1
  } reg_issue_state_e;

endpackage

// File: rtl/reg_issue_sched_rr_arbiter.sv
// Round-robin winner selection: the first asserted request found when
// scanning from ptr upwards, wrapping modulo N.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          valid
);

  // Scan from the farthest offset down to ptr so the closest request is the
  // last one written and therefore wins.
  always_comb begin
    int idx;
    gnt_idx = '0;
    valid   = |req;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) gnt_idx = IW'(idx);
    end
  end

endmodule

// File: rtl/reg_issue_sched.sv
// Issue scheduler between NUM_PL decode pipelines and the execute port.
// Owns the register lock scoreboard; one issue per cycle, round-robin.
//
// Optional build macro: REG_ISSUE_SCHED_UNLOCK_BYPASS_EN
//   defined   - registers released by unlock_i this cycle already count as
//               free for eligibility (0-cycle wake-up, unlock_i reaches
//               pl_ready_o combinationally).
//   undefined - eligibility looks only at the registered locks (1-cycle
//               wake-up).
//
// state     | meaning
// ----------+------------------------------------------------------------
// RUN       | normal issue; locks follow set/unlock rules
// JUMP_WAIT | jump in flight; all registers locked, nothing issues until
//           | jump_clr_i (or flush_i)
module reg_issue_sched
  import rv64g_pkg::*;
#(
  parameter  int NR     = NUM_REGS,
  parameter  int NUM_PL = NUM_ISSUE_PL,
  localparam int RW     = $clog2(NR),
  localparam int SW     = (NUM_PL > 1) ? $clog2(NUM_PL) : 1
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic                       flush_i,
  input  logic [NUM_PL-1:0]          pl_valid_i,
  input  logic [NUM_PL-1:0]          jump_i,
  input  logic [NUM_PL-1:0][RW-1:0]  rd_i,
  input  logic [NUM_PL-1:0][NR-1:0]  reg_req_i,
  output logic [NUM_PL-1:0]          pl_ready_o,
  output logic                       issue_valid_o,
  output logic [SW-1:0]              issue_sel_o,
  input  logic                       issue_ready_i,
  input  logic [NR-1:0]              unlock_i,
  input  logic                       jump_clr_i,
  output logic [NR-1:0]              locks_o,
  output logic                       busy_o
);

  reg_issue_state_e state_q, state_d;
  logic [NR-1:0]     locks_q, locks_d;
  logic [SW-1:0]     ptr_q, ptr_d;
  logic [NR-1:0]     eff_locks;
  logic [NUM_PL-1:0] elig;
  logic [SW-1:0]     win_idx;
  logic              win_valid;
  logic              accept;
  logic [NR-1:0]     set_mask;

`ifdef REG_ISSUE_SCHED_UNLOCK_BYPASS_EN
  assign eff_locks = (state_q == RUN) ? (locks_q & ~unlock_i) : locks_q;
`else
  assign eff_locks = locks_q;
`endif

  // Per-pipeline eligibility: every needed register free, RUN, no flush.
  // Reset also masks requests so the handshake outputs read 0 immediately.
  always_comb begin
    logic [NR-1:0] need;
    elig = '0;
    need = '0;
    for (int p = 0; p < NUM_PL; p++) begin
      need    = reg_req_i[p] | ((NR'(1) << rd_i[p]) & ~NR'(1));
      elig[p] = pl_valid_i[p] & ~|(eff_locks & need) & (state_q == RUN)
                & ~flush_i & ~arst_i;
    end
  end

  rr_arbiter #(.N(NUM_PL)) u_arb (
    .req     (elig),
    .ptr     (ptr_q),
    .gnt_idx (win_idx),
    .valid   (win_valid)
  );

  assign issue_valid_o = win_valid;
  assign issue_sel_o   = win_idx;
  assign accept        = win_valid & issue_ready_i;
  assign locks_o       = locks_q;
  assign busy_o        = (state_q == JUMP_WAIT);

  // One-hot ready to the accepted pipeline only.
  always_comb begin
    pl_ready_o = '0;
    if (accept) pl_ready_o = NUM_PL'(1) << win_idx;
  end

  // Destination lock for a non-jump accept; x0 never locks.
  always_comb begin
    set_mask = '0;
    if (accept) set_mask = (NR'(1) << rd_i[win_idx]) & ~NR'(1);
  end

  // Next state, scoreboard and pointer; flush dominates everything.
  always_comb begin
    state_d = state_q;
    locks_d = locks_q;
    ptr_d   = ptr_q;
    if (flush_i) begin
      state_d = RUN;
      locks_d = '0;
    end else if (state_q == JUMP_WAIT) begin
      if (jump_clr_i) begin
        state_d = RUN;
        locks_d = '0;
      end
    end else if (accept && jump_i[win_idx]) begin
      state_d = JUMP_WAIT;
      locks_d = '1;
    end else begin
      locks_d = (locks_q & ~unlock_i) | set_mask;
    end
    if (accept) begin
      ptr_d = (win_idx == SW'(NUM_PL - 1)) ? '0 : win_idx + SW'(1);
    end
  end

  // State, scoreboard and round-robin pointer registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= RUN;
      locks_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      locks_q <= locks_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: doc/reg_issue_sched.md
Name: reg_issue_sched

Overview:
- Issue scheduler between NUM_PL decode pipelines and the single execute issue port.
- Owns the architectural register lock scoreboard (flops).
- Each cycle, selects at most one pipeline whose required source and destination registers are all unlocked, using round-robin priority.
- On accepted issue, applies the destination/jump locking rules; write-back unlocks release registers.

Parameters:
- NR, rv64g_pkg::NUM_REGS, number of architectural registers.
- NUM_PL, 2, number of requesting pipelines (>=1).

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  asynchronous active-high reset.
- flush_i  in  1  synchronous flush; clears all locks, returns to RUN.
- pl_valid_i  in  NUM_PL  per-pipeline instruction valid.
- jump_i  in  NUM_PL  per-pipeline jump flag.
- rd_i  in  NUM_PL x $clog2(NR)  per-pipeline destination index.
- reg_req_i  in  NUM_PL x NR  per-pipeline source register mask.
- pl_ready_o  out  NUM_PL  one-hot (or zero) accept to pipelines.
- issue_valid_o  out  1  an instruction is presented to execute.
- issue_sel_o  out  $clog2(NUM_PL) (min 1)  index of the selected pipeline.
- issue_ready_i  in  1  execute accepts this cycle.
- unlock_i  in  NR  write-back release mask.
- jump_clr_i  in  1  jump resolved; release the global lock.
- locks_o  out  NR  current lock scoreboard (registered).
- busy_o  out  1  state is JUMP_WAIT.

Behaviour:
- Reset (async, arst_i=1):
  - locks_q='0, ptr_q=0, state=RUN.
  - All outputs 0.
- Effective locks:
  - eff_locks = locks_q.
  - See Optional Feature for bypass.
- Eligibility:
  - need[p] = reg_req_i[p] | onehot(rd_i[p]), with bit 0 of the onehot forced to 0.
  - elig[p] = pl_valid_i[p] & ~|(eff_locks & need[p]) & (state==RUN) & ~flush_i.
- Arbitration:
  - Winner is the first eligible p scanning ptr_q, ptr_q+1, ..., wrapping modulo NUM_PL.
  - issue_valid_o = |elig; issue_sel_o = winner. Both are combinational from current inputs.
- Handshake:
  - pl_ready_o[winner] = issue_valid_o & issue_ready_i; all other bits 0.
  - An issue is accepted when issue_valid_o & issue_ready_i.
  - The winner is not held across cycles; arbitration is recomputed every cycle.
- Pointer:
  - On accept, ptr_q <= (winner+1) mod NUM_PL.
  - Otherwise ptr_q holds.
- Lock next-state, in RUN, no flush:
  - locks_d = (locks_q & ~unlock_i) | set.
  - set = onehot(rd) with x0 masked if the accepted instruction is not a jump.
  - set = 0 if nothing is accepted.
  - Same-cycle unlock and set of the same register: the set wins (register stays locked).
- Accepted jump:
  - locks_d = '1, including bit 0. unlock_i in that cycle is ignored.
  - state <= JUMP_WAIT.
- JUMP_WAIT:
  - No eligibility; pl_ready_o=0. unlock_i is ignored and locks hold '1.
  - On jump_clr_i: locks <= '0, state <= RUN.
  - jump_clr_i in RUN is ignored.
- flush_i:
  - Highest priority over accept, unlock and jump_clr_i.
  - Next cycle: locks='0, state=RUN, ptr_q unchanged.
  - No accept occurs in the flush cycle.
- busy_o = (state==JUMP_WAIT), registered.
- No accept while issue_ready_i=0: locks only lose unlock_i bits.
- rd_i=0 with jump_i=0: issues without locking anything.
- Latency:
  - Lock takes effect for eligibility the cycle after accept.
  - Unlock takes effect the cycle after unlock_i (without the feature).

Optional Feature:
- Macro: REG_ISSUE_SCHED_UNLOCK_BYPASS_EN.
- Defined:
  - eff_locks = locks_q & ~unlock_i in RUN.
  - A register released this cycle can satisfy a requester in the same cycle (0-cycle wake-up).
  - Adds a combinational path from unlock_i to pl_ready_o.
- Undefined:
  - eff_locks = locks_q; 1-cycle wake-up.
  - No combinational path from unlock_i to the handshake outputs.

Decomposition:
- rv64g_pkg:
  - NUM_REGS, already present.
  - New typedef reg_issue_state_e {RUN, JUMP_WAIT}.
  - Constant NUM_ISSUE_PL=2, used as the parameter default by integrating tops.
- Sub-module: rr_arbiter (parameter N; inputs req[N] and ptr; outputs gnt_idx and valid).
  - The scheduler instantiates it for winner selection.
  - Lock logic stays in the top.

Test Plan:
- Reset, then pl0 valid with rd=5, reqs={1,2}, issue_ready=1 → pl_ready_o=01, next cycle locks_o=0x20.
- locks has bit 5 set, then pl1 requests src 5 → issue_valid_o=0.
  - Pulse unlock_i=0x20 → pl1 granted one cycle later.
  - With the bypass macro defined, pl1 is granted in the same cycle.
- Both pipelines continuously eligible with rd=0, issue_ready=1 → grants alternate 01,10,01,10.
  - Hold issue_ready=0 for 3 cycles → ptr unchanged and no lock change.
- pl0 jump accepted → locks_o='1, busy_o=1, pl_ready_o=0 even with valid requests and unlock_i='1.
  - jump_clr_i → locks='0, busy_o=0.
- Same cycle: unlock_i bit 7 and accept of an instruction with rd=7 → locks_o[7]=1 next cycle.
  - rd=0 non-jump accept → locks_o[0] stays 0.
- flush_i together with an eligible request and jump_clr_i → no pl_ready_o, locks='0, state RUN.
  - arst_i asserted mid-JUMP_WAIT → outputs 0 immediately.
